// File: rtl/spi_controller.sv
// spi_controller: CPU-mapped SPI master (mode 0, MSB first), one byte per transfer.
// Registers: 0 DATA (write starts a transfer, read returns last rx byte and clears DONE),
//            1 CTRL/STATUS (bit0 BUSY, bit1 CS, bit7 DONE), 2 DIV, 3 reserved.
module spi_controller #(
  parameter logic [7:0] DEFAULT_DIV = 8'd3,
  parameter int         NUM_BITS    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       sd_cs,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [3:0] LAST_BIT = 4'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_t;

  state_t     state_q;
  logic       busy_q;
  logic       done_q;
  logic       cs_bit_q;
  logic       sclk_q;
  logic       mosi_q;
  logic [7:0] div_q;
  logic [7:0] div_active_q;
  logic [7:0] half_cnt_q;
  logic [7:0] tx_sh_q;
  logic [7:0] rx_sh_q;
  logic [7:0] rx_q;
  logic [3:0] bit_cnt_q;

  logic wr_data;
  logic rd_data;
  logic wr_ctrl;
  logic wr_div;
  logic half_end;

  assign sd_cs    = cs_bit_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;

  // Bus decode strobes and end-of-half-period flag.
  always_comb begin
    wr_data  = cs && we  && (addr == 2'd0);
    rd_data  = cs && !we && (addr == 2'd0);
    wr_ctrl  = cs && we  && (addr == 2'd1);
    wr_div   = cs && we  && (addr == 2'd2);
    half_end = (half_cnt_q == div_active_q);
  end

  // Read mux; combinational from addr so the CPU sees data in the same cycle.
  always_comb begin
    o_data = '0;
    unique case (addr)
      2'd0:    o_data = rx_q;
      2'd1:    o_data = {done_q, 5'b0, cs_bit_q, busy_q};
      2'd2:    o_data = div_q;
      default: o_data = '0;
    endcase
  end

  // Register file and bit-shifting state machine. The DONE clear from a
  // DATA read is assigned before the FSM so a coincident completion wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cs_bit_q     <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b1;
      div_q        <= DEFAULT_DIV;
      div_active_q <= DEFAULT_DIV;
      half_cnt_q   <= '0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
    end else begin
      if (wr_ctrl) cs_bit_q <= i_data[1];
      if (wr_div)  div_q    <= i_data;
      if (rd_data) done_q   <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (wr_data) begin
            tx_sh_q      <= i_data;
            div_active_q <= div_q;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            mosi_q       <= i_data[7];
            half_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            state_q      <= S_LOW;
          end
        end
        S_LOW: begin
          if (half_end) begin
            half_cnt_q <= '0;
            sclk_q     <= 1'b1;
            rx_sh_q    <= {rx_sh_q[6:0], spi_miso};
            state_q    <= S_HIGH;
          end else begin
            half_cnt_q <= half_cnt_q + 8'd1;
          end
        end
        S_HIGH: begin
          if (half_end) begin
            half_cnt_q <= '0;
            sclk_q     <= 1'b0;
            bit_cnt_q  <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              rx_q    <= rx_sh_q;
              mosi_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              tx_sh_q <= {tx_sh_q[6:0], 1'b0};
              mosi_q  <= tx_sh_q[6];
              state_q <= S_LOW;
            end
          end else begin
            half_cnt_q <= half_cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed and randomized transfers against a mode-0 slave
// model; expected timing and data come from the register-level rules.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic [1:0] addr;
  logic       we;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       sd_cs;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_controller #(
    .DEFAULT_DIV(8'd3),
    .NUM_BITS   (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .addr    (addr),
    .we      (we),
    .i_data  (i_data),
    .o_data  (o_data),
    .sd_cs   (sd_cs),
    .spi_clk (spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  // Slave model: presents MSB before the first rising SCLK, next bit after each falling SCLK.
  logic [7:0] slv_byte  = 8'hFF;
  int         fall_cnt  = 0;
  int         fall_base = 0;

  always @(negedge spi_clk) fall_cnt++;

  always_comb begin
    int k;
    k = fall_cnt - fall_base;
    spi_miso = (k >= 0 && k < 8) ? slv_byte[7-k] : 1'b1;
  end

  // Line monitor: MOSI at each SCLK rise, and lengths of every SCLK high/low run.
  logic prev_sclk = 1'b0;
  int   run = 0;
  logic mosi_seen[$];
  int   high_runs[$];
  int   low_runs[$];

  always @(negedge clk) begin
    if (spi_clk !== prev_sclk) begin
      if (prev_sclk === 1'b1) high_runs.push_back(run);
      else                    low_runs.push_back(run);
      if (spi_clk === 1'b1) mosi_seen.push_back(spi_mosi);
      run = 1;
    end else begin
      run++;
    end
    prev_sclk = spi_clk;
  end

  int mb, hb, lb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; i_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    #1 d = o_data;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] resp);
    slv_byte  = resp;
    fall_base = fall_cnt;
    mb = mosi_seen.size();
    hb = high_runs.size();
    lb = low_runs.size();
    bus_wr(2'd0, tx);
  endtask

  // Waits for BUSY to drop, then checks busy length, pulse count, MOSI byte and phase lengths.
  task automatic finish_xfer(input string tag, input logic [7:0] exp_tx, input int div,
                             input int skip);
    int n;
    int bad;
    logic [7:0] got;
    n = 0;
    addr = 2'd1;
    @(negedge clk);
    while (o_data[0] === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    chk({tag, "_busy_cycles"}, n, 16 * (div + 1) - skip);
    chk({tag, "_sclk_pulses"}, mosi_seen.size() - mb, 8);
    got = '0;
    for (int i = 0; i < 8; i++)
      if (mb + i < mosi_seen.size()) got = {got[6:0], mosi_seen[mb+i]};
    chk({tag, "_mosi_byte"}, got, exp_tx);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (hb + i >= high_runs.size() || high_runs[hb+i] != div + 1) bad++;
    for (int i = 1; i < 8; i++)
      if (lb + i >= low_runs.size() || low_runs[lb+i] != div + 1) bad++;
    chk({tag, "_bad_phases"}, bad, 0);
  endtask

  logic [7:0] rd;
  logic [7:0] cmd0 [6];

  initial begin
    reset = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; i_data = 8'h00;
    cmd0[0] = 8'h40; cmd0[1] = 8'h00; cmd0[2] = 8'h00;
    cmd0[3] = 8'h00; cmd0[4] = 8'h00; cmd0[5] = 8'h95;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sd_cs", sd_cs, 1'b1);
    chk("rst_spi_clk", spi_clk, 1'b0);
    chk("rst_spi_mosi", spi_mosi, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    bus_rd(2'd1, rd); chk("rst_status", rd, 8'h02);
    bus_rd(2'd2, rd); chk("rst_div", rd, 8'h03);
    bus_rd(2'd0, rd); chk("rst_data", rd, 8'h00);
    bus_rd(2'd3, rd); chk("addr3_read", rd, 8'h00);

    // DIV=0, CS low, A5 out / 3C in
    bus_wr(2'd2, 8'h00);
    bus_wr(2'd1, 8'h00);
    chk("cs_low", sd_cs, 1'b0);
    start_xfer(8'hA5, 8'h3C);
    finish_xfer("a5", 8'hA5, 0, 0);
    bus_rd(2'd1, rd); chk("a5_status_done", rd, 8'h80);
    bus_rd(2'd0, rd); chk("a5_rx", rd, 8'h3C);
    bus_rd(2'd1, rd); chk("a5_status_clr", rd, 8'h00);

    // DATA read on the very cycle DONE sets: DONE must stay set
    start_xfer(8'h5A, 8'hC3);
    repeat (15) @(posedge clk);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = 2'd0;
    @(posedge clk);
    #1 cs = 1'b0;
    bus_rd(2'd1, rd); chk("coinc_status", rd, 8'h80);
    bus_rd(2'd0, rd); chk("coinc_rx", rd, 8'hC3);

    // DIV=3, FF out
    bus_wr(2'd2, 8'h03);
    start_xfer(8'hFF, 8'h81);
    finish_xfer("ff", 8'hFF, 3, 0);
    bus_rd(2'd0, rd); chk("ff_rx", rd, 8'h81);

    // Second DATA write during BUSY ignored
    bus_wr(2'd2, 8'h00);
    start_xfer(8'h12, 8'h6B);
    repeat (3) @(posedge clk);
    bus_wr(2'd0, 8'h34);
    finish_xfer("ign", 8'h12, 0, 4);
    bus_rd(2'd0, rd); chk("ign_rx", rd, 8'h6B);

    // DIV write mid-transfer applies only to the next transfer
    start_xfer(8'hC6, 8'h5E);
    bus_wr(2'd2, 8'h02);
    finish_xfer("divmid", 8'hC6, 0, 1);
    bus_rd(2'd2, rd); chk("divmid_readback", rd, 8'h02);
    start_xfer(8'h3B, 8'hE4);
    finish_xfer("divnext", 8'h3B, 2, 0);
    bus_rd(2'd0, rd); chk("divnext_rx", rd, 8'hE4);

    // CS raised mid-byte: sd_cs follows at once, transfer still completes
    bus_wr(2'd2, 8'h00);
    start_xfer(8'h99, 8'h42);
    bus_wr(2'd1, 8'h02);
    chk("cs_mid_sd_cs", sd_cs, 1'b1);
    finish_xfer("csmid", 8'h99, 0, 1);
    bus_rd(2'd1, rd); chk("csmid_status", rd, 8'h82);
    bus_rd(2'd0, rd); chk("csmid_rx", rd, 8'h42);
    bus_wr(2'd1, 8'h00);

    // Randomized transfers
    for (int t = 0; t < 6; t++) begin
      int         dv;
      logic [7:0] tx;
      logic [7:0] rs;
      dv = int'($urandom_range(0, 3));
      tx = 8'($urandom);
      rs = 8'($urandom);
      bus_wr(2'd2, 8'(dv));
      start_xfer(tx, rs);
      finish_xfer($sformatf("rnd%0d", t), tx, dv, 0);
      bus_rd(2'd1, rd); chk($sformatf("rnd%0d_status", t), rd, 8'h80);
      bus_rd(2'd0, rd); chk($sformatf("rnd%0d_rx", t), rd, rs);
    end

    // Reset at cycle 10 of a DIV=1 transfer
    bus_wr(2'd2, 8'h01);
    start_xfer(8'h96, 8'h77);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_spi_clk", spi_clk, 1'b0);
    chk("abort_spi_mosi", spi_mosi, 1'b1);
    chk("abort_sd_cs", sd_cs, 1'b1);
    addr = 2'd1; #1 chk("abort_status", o_data, 8'h02);
    addr = 2'd0; #1 chk("abort_rx", o_data, 8'h00);
    addr = 2'd2; #1 chk("abort_div", o_data, 8'h03);
    @(negedge clk);
    reset = 1'b1;

    // SD init: 10 x FF with CS high, then CMD0 with CS low, R1 = 01
    bus_wr(2'd2, 8'h00);
    bus_wr(2'd1, 8'h02);
    for (int i = 0; i < 10; i++) begin
      start_xfer(8'hFF, 8'hFF);
      finish_xfer($sformatf("init%0d", i), 8'hFF, 0, 0);
    end
    bus_wr(2'd1, 8'h00);
    chk("cmd0_cs_low", sd_cs, 1'b0);
    for (int i = 0; i < 6; i++) begin
      start_xfer(cmd0[i], 8'hFF);
      finish_xfer($sformatf("cmd0_%0d", i), cmd0[i], 0, 0);
    end
    start_xfer(8'hFF, 8'h01);
    finish_xfer("r1", 8'hFF, 0, 0);
    bus_rd(2'd0, rd); chk("r1_value", rd, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
